// File: rtl/ace_bus_controller_pkg.sv
// ace_pkg: shared definitions for the ACE bus controller.
// Contents:
//   state_t          controller FSM states
//   op_t             which request kind was accepted
//   ARSNOOP_*        read-address snoop encodings (ReadShared, CleanUnique)
//   AWSNOOP_*        write-address snoop encoding (WriteBack)
//   RESP_*           AXI/ACE response codes
//   resp_is_error    true for SLVERR/DECERR
package ace_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        INV_ADDR,
        INV_DATA,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_INV
    } op_t;

    localparam logic [3:0] ARSNOOP_READ_SHARED  = 4'b0001;
    localparam logic [3:0] ARSNOOP_CLEAN_UNIQUE = 4'b1011;
    localparam logic [2:0] AWSNOOP_WRITE_BACK   = 3'b011;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/ace_bus_controller_if.sv
// ace_bus_controller_if: ACE channel bundle between the controller and the
// coherent interconnect.
// Channels:
//   AR  araddr/arlen/arsnoop/arvalid -> , <- arready
//   R   <- rdata/rresp/rlast/rvalid , rready/rack ->
//   AW  awaddr/awlen/awsnoop/awvalid -> , <- awready
//   W   wdata/wlast/wvalid -> , <- wready
//   B   <- bresp/bvalid , bready/wack ->
// Modports: master (controller side), slave (interconnect side).
interface ace_bus_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [3:0]            arsnoop;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [3:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  rack;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsnoop;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic                  wack;

    modport master (
        output araddr, arlen, arsnoop, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready, rack,
        output awaddr, awlen, awsnoop, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready, wack
    );

    modport slave (
        input  araddr, arlen, arsnoop, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready, rack,
        input  awaddr, awlen, awsnoop, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready, wack
    );

endinterface

// File: rtl/ace_bus_controller.sv
// ace_bus_controller: turns cache-controller requests into ACE transactions.
//   read_req    -> ReadShared line fill, fill_data assembled beat by beat
//   write_req   -> WriteBack of wb_data
//   invalid_req -> CleanUnique upgrade (single R beat, data discarded)
// Ports:
//   clk, reset (async, active-low)
//   read_req, write_req, invalid_req, req_addr, wb_data  from the cache controller
//   fill_data, ace_ready, ace_error                      back to the cache controller
//   bus                                                  ACE master channels
module ace_bus_controller
    import ace_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             read_req,
    input  logic                             write_req,
    input  logic                             invalid_req,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_data,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] fill_data,
    output logic                             ace_ready,
    output logic                             ace_error,
    ace_bus_controller_if.master             bus
);

    localparam int                   CNT_WIDTH = $clog2(LINE_WORDS);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(LINE_WORDS - 1);
    localparam logic [7:0]           LINE_LEN  = 8'(LINE_WORDS - 1);

    state_t                          state;
    state_t                          state_n;
    op_t                             op_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_q;
    logic [LINE_WORDS*DATA_WIDTH-1:0] fill_q;
    logic [CNT_WIDTH-1:0]            cnt;
    logic                            err_q;
    logic                            overflow_q;
    logic                            any_req;

    // Only the error bit of each response is meaningful to this controller.
    logic unused_resp_bits;
    assign unused_resp_bits = ^{bus.rresp[3:2], bus.rresp[0], bus.bresp[0]};

    assign any_req   = read_req | write_req | invalid_req;
    assign fill_data = fill_q;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and bus outputs. All outputs derive from state (and the
    // latched request), so they are zero in reset and stable while a valid
    // is waiting for its ready.
    always_comb begin
        state_n     = state;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsnoop = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.rack    = 1'b0;
        bus.awaddr  = '0;
        bus.awlen   = '0;
        bus.awsnoop = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wlast   = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.wack    = 1'b0;
        ace_ready   = 1'b0;
        ace_error   = 1'b0;
        case (state)
            IDLE: begin
                if (write_req)        state_n = WR_ADDR;
                else if (invalid_req) state_n = INV_ADDR;
                else if (read_req)    state_n = RD_ADDR;
            end
            RD_ADDR: begin
                bus.arvalid = 1'b1;
                bus.araddr  = addr_q;
                bus.arlen   = LINE_LEN;
                bus.arsnoop = ARSNOOP_READ_SHARED;
                if (bus.arready) state_n = RD_DATA;
            end
            RD_DATA: begin
                bus.rready = 1'b1;
                if (bus.rvalid && bus.rlast) state_n = DONE;
            end
            WR_ADDR: begin
                bus.awvalid = 1'b1;
                bus.awaddr  = addr_q;
                bus.awlen   = LINE_LEN;
                bus.awsnoop = AWSNOOP_WRITE_BACK;
                if (bus.awready) state_n = WR_DATA;
            end
            WR_DATA: begin
                bus.wvalid = 1'b1;
                bus.wdata  = line_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH];
                bus.wlast  = (cnt == LAST_BEAT);
                if (bus.wready && cnt == LAST_BEAT) state_n = WR_RESP;
            end
            WR_RESP: begin
                bus.bready = 1'b1;
                if (bus.bvalid) state_n = DONE;
            end
            INV_ADDR: begin
                bus.arvalid = 1'b1;
                bus.araddr  = addr_q;
                bus.arlen   = 8'd0;
                bus.arsnoop = ARSNOOP_CLEAN_UNIQUE;
                if (bus.arready) state_n = INV_DATA;
            end
            INV_DATA: begin
                bus.rready = 1'b1;
                if (bus.rvalid) state_n = DONE;
            end
            DONE: begin
                ace_ready = 1'b1;
                ace_error = err_q;
                bus.rack  = (op_q != OP_WRITE);
                bus.wack  = (op_q == OP_WRITE);
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, beat counter, fill line and error tracking. A read that
    // runs past the line without rlast sets overflow_q so extra beats are
    // consumed but never written into fill_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= OP_READ;
            addr_q     <= '0;
            line_q     <= '0;
            fill_q     <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        addr_q     <= req_addr;
                        line_q     <= wb_data;
                        cnt        <= '0;
                        err_q      <= 1'b0;
                        overflow_q <= 1'b0;
                        op_q       <= write_req   ? OP_WRITE :
                                      invalid_req ? OP_INV : OP_READ;
                    end
                end
                RD_DATA: begin
                    if (bus.rvalid) begin
                        if (!overflow_q) begin
                            fill_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= bus.rdata;
                        end
                        cnt <= cnt + 1'b1;
                        if (resp_is_error(bus.rresp[1:0])) err_q <= 1'b1;
                        if (bus.rlast && cnt != LAST_BEAT) err_q <= 1'b1;
                        if (!bus.rlast && cnt == LAST_BEAT) begin
                            err_q      <= 1'b1;
                            overflow_q <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (bus.wready) cnt <= cnt + 1'b1;
                end
                WR_RESP: begin
                    if (bus.bvalid && resp_is_error(bus.bresp)) err_q <= 1'b1;
                end
                INV_DATA: begin
                    if (bus.rvalid && resp_is_error(bus.rresp[1:0])) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_bus_controller.sv
// tb_ace_bus_controller: directed self-checking bench for ace_bus_controller
// (ADDR_WIDTH=32, DATA_WIDTH=32, LINE_WORDS=4). Acts as cache controller and
// as the ACE slave; inputs are driven 1 time unit after the rising edge and
// outputs are sampled in the same slot.
module tb_ace_bus_controller;

    logic         clk;
    logic         reset;
    logic         read_req;
    logic         write_req;
    logic         invalid_req;
    logic [31:0]  req_addr;
    logic [127:0] wb_data;
    logic [127:0] fill_data;
    logic         ace_ready;
    logic         ace_error;

    int testsRun  = 0;
    int testsFail = 0;
    int readyCount = 0;
    int rackCount  = 0;
    int wackCount  = 0;
    int readyBase;
    int rackBase;
    int wackBase;
    int k;

    ace_bus_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ace_bus_controller #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LINE_WORDS(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_req   (read_req),
        .write_req  (write_req),
        .invalid_req(invalid_req),
        .req_addr   (req_addr),
        .wb_data    (wb_data),
        .fill_data  (fill_data),
        .ace_ready  (ace_ready),
        .ace_error  (ace_error),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, used to prove "exactly once"/"never".
    always @(negedge clk) begin
        if (ace_ready) readyCount++;
        if (bus.rack)  rackCount++;
        if (bus.wack)  wackCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic inv,
                                 input logic [31:0] addr, input logic [127:0] line);
        read_req    = rd;
        write_req   = wr;
        invalid_req = inv;
        req_addr    = addr;
        wb_data     = line;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitReady(input string tag);
        for (int c = 0; c < 20; c++) begin
            if (ace_ready) break;
            tick();
        end
        checkOutput(tag, ace_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, '0);
        bus.arready = 0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bresp = '0; bus.bvalid = 0;

        // Reset state
        repeat (2) tick();
        checkOutput("rst_ready", ace_ready, 1'b0);
        checkOutput("rst_outs", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                                 bus.bready, bus.rack, bus.wack, ace_error}, 8'h00);
        checkOutput("rst_fill", fill_data, 128'h0);
        reset = 1'b1;
        tick();

        // Read, zero-wait slave: request in cycle 1, ace_ready in cycle 7
        rackBase = rackCount;
        applyStimulus(1, 0, 0, 32'h1000, '0);
        bus.arready = 1;
        tick();
        checkOutput("rd_ar", {bus.arvalid, bus.araddr, bus.arlen, bus.arsnoop},
                    {1'b1, 32'h1000, 8'd3, 4'b0001});
        tick();
        bus.arready = 0;
        checkOutput("rd_rready", bus.rready, 1'b1);
        for (int b = 0; b < 4; b++) begin
            bus.rvalid = 1;
            bus.rdata  = 32'hA0 + b;
            bus.rlast  = (b == 3);
            if (b == 3) checkOutput("rd_not_early", ace_ready, 1'b0);
            tick();
        end
        bus.rvalid = 0; bus.rlast = 0; read_req = 0;
        checkOutput("rd_ready_c7", {ace_ready, ace_error, bus.rack, bus.wack}, 4'b1010);
        checkOutput("rd_fill", fill_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        tick();
        checkOutput("rd_rack_once", rackCount - rackBase, 1);
        checkOutput("rd_idle", {ace_ready, bus.arvalid}, 2'b00);

        // Writeback, awready delayed 3 cycles, wready toggling
        applyStimulus(0, 1, 0, 32'h2000, {32'h44, 32'h33, 32'h22, 32'h11});
        tick();
        for (int c = 0; c < 3; c++) begin
            checkOutput("wr_aw_hold", {bus.awvalid, bus.awaddr, bus.awlen, bus.awsnoop},
                        {1'b1, 32'h2000, 8'd3, 3'b011});
            tick();
        end
        bus.awready = 1;
        tick();
        bus.awready = 0;
        k = 0;
        for (int c = 0; c < 16 && k < 4; c++) begin
            bus.wready = c[0];
            checkOutput("wr_wvalid", bus.wvalid, 1'b1);
            checkOutput("wr_wdata", bus.wdata, 32'h11 * (k + 1));
            checkOutput("wr_wlast", bus.wlast, (k == 3));
            if (bus.wready) k++;
            tick();
        end
        checkOutput("wr_beats", k, 4);
        bus.wready = 0;
        checkOutput("wr_resp", {bus.bready, bus.wvalid, ace_ready}, 3'b100);
        bus.bvalid = 1;
        tick();
        bus.bvalid = 0; write_req = 0;
        checkOutput("wr_done", {ace_ready, ace_error, bus.wack, bus.rack}, 4'b1010);
        tick();
        checkOutput("wr_idle", {ace_ready, bus.wack}, 2'b00);

        // Invalidate from a single-cycle pulse
        readyBase = readyCount;
        applyStimulus(0, 0, 1, 32'h3000, '0);
        tick();
        invalid_req = 0;
        checkOutput("inv_ar", {bus.arvalid, bus.araddr, bus.arlen, bus.arsnoop},
                    {1'b1, 32'h3000, 8'd0, 4'b1011});
        bus.arready = 1;
        tick();
        bus.arready = 0;
        checkOutput("inv_rready", bus.rready, 1'b1);
        bus.rvalid = 1; bus.rdata = 32'hDEADBEEF; bus.rlast = 1;
        tick();
        bus.rvalid = 0; bus.rlast = 0;
        checkOutput("inv_done", {ace_ready, ace_error, bus.rack, bus.wack}, 4'b1010);
        checkOutput("inv_fill", fill_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        repeat (3) tick();
        checkOutput("inv_ready_once", readyCount - readyBase, 1);
        checkOutput("inv_no_reissue", bus.arvalid, 1'b0);

        // write_req + read_req together: WriteBack first, then ReadShared
        applyStimulus(1, 1, 0, 32'h4000, {4{32'h55}});
        bus.awready = 1; bus.wready = 1; bus.bvalid = 1;
        tick();
        checkOutput("prio_wr", {bus.awvalid, bus.arvalid}, 2'b10);
        waitReady("prio_wb_ready");
        checkOutput("prio_wack", bus.wack, 1'b1);
        write_req = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
        tick();
        checkOutput("pend_idle", {bus.arvalid, bus.awvalid}, 2'b00);
        tick();
        checkOutput("pend_ar", {bus.arvalid, bus.arsnoop, bus.araddr},
                    {1'b1, 4'b0001, 32'h4000});

        // Same read ends with SLVERR and early rlast on beat 2
        bus.arready = 1;
        tick();
        bus.arready = 0;
        for (int b = 0; b < 3; b++) begin
            bus.rvalid = 1;
            bus.rdata  = 32'hB0 + b;
            bus.rresp  = (b == 2) ? 4'b0010 : 4'b0000;
            bus.rlast  = (b == 2);
            tick();
        end
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = '0; read_req = 0;
        checkOutput("err_done", {ace_ready, ace_error, bus.rack}, 3'b111);
        checkOutput("err_fill", fill_data, {32'hA3, 32'hB2, 32'hB1, 32'hB0});
        tick();
        checkOutput("err_idle", {ace_ready, ace_error, bus.arvalid, bus.rready}, 4'b0000);

        // Missing rlast on beat 3: fifth beat discarded, error flagged
        applyStimulus(1, 0, 0, 32'h5000, '0);
        bus.arready = 1;
        tick();
        tick();
        bus.arready = 0;
        for (int b = 0; b < 5; b++) begin
            bus.rvalid = 1;
            bus.rdata  = 32'hC0 + b;
            bus.rlast  = (b == 4);
            tick();
        end
        bus.rvalid = 0; bus.rlast = 0; read_req = 0;
        checkOutput("ovf_done", {ace_ready, ace_error}, 2'b11);
        checkOutput("ovf_fill", fill_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        tick();

        // Asynchronous reset during WR_DATA
        applyStimulus(0, 1, 0, 32'h6000, {4{32'h77}});
        bus.awready = 1;
        tick();
        tick();
        bus.awready = 0;
        checkOutput("rst_pre_wdata", bus.wvalid, 1'b1);
        readyBase = readyCount;
        wackBase  = wackCount;
        reset = 1'b0;
        #1;
        checkOutput("rst_async", {bus.wvalid, bus.awvalid, bus.bready, bus.wack,
                                  bus.rack, ace_ready, ace_error}, 7'h00);
        checkOutput("rst_async_fill", fill_data, 128'h0);
        write_req = 0;
        tick();
        tick();
        reset = 1'b1;
        bus.wready = 1; bus.bvalid = 1;
        repeat (4) tick();
        checkOutput("rst_no_ack", (readyCount - readyBase) + (wackCount - wackBase), 0);
        checkOutput("rst_idle", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid}, 4'b0000);
        bus.wready = 0; bus.bvalid = 0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/ace_bus_controller.md
Name: ace_bus_controller

Overview:
- Downstream of the cache controller; converts its read_req / write_req / invalid_req into ACE bus transactions.
  - Line fills: ReadShared.
  - Dirty-line writebacks: WriteBack.
  - Upgrades to unique: CleanUnique.
- Returns a one-cycle ace_ready completion pulse, with the filled line when the request was a read.
- Sits between the cache controller/datapath and the coherent interconnect.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, bus beat width
LINE_WORDS, 4, beats per cache line (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
read_req  in  1  line fill request (held by controller until ace_ready)
write_req  in  1  writeback request (held until ace_ready)
invalid_req  in  1  invalidate/upgrade request (may be a single-cycle pulse)
req_addr  in  ADDR_WIDTH  line address, sampled at accept
wb_data  in  LINE_WORDS*DATA_WIDTH  dirty line, sampled at accept
fill_data  out  LINE_WORDS*DATA_WIDTH  assembled fill line
ace_ready  out  1  one-cycle completion pulse
ace_error  out  1  one-cycle pulse with ace_ready on bad response/protocol error
araddr  out  ADDR_WIDTH;  arlen  out  8;  arsnoop  out  4;  arvalid  out  1;  arready  in  1
rdata  in  DATA_WIDTH;  rresp  in  4;  rlast  in  1;  rvalid  in  1;  rready  out  1;  rack  out  1
awaddr  out  ADDR_WIDTH;  awlen  out  8;  awsnoop  out  3;  awvalid  out  1;  awready  in  1
wdata  out  DATA_WIDTH;  wlast  out  1;  wvalid  out  1;  wready  in  1
bresp  in  2;  bvalid  in  1;  bready  out  1;  wack  out  1

Behaviour:
Reset:
- All outputs are 0, fill_data is 0, and the FSM is in IDLE.
- Reset mid-transaction abandons it immediately. No ack is issued.

Requests:
- Requests are sampled only in IDLE. Priority: write_req > invalid_req > read_req.
- req_addr and wb_data are latched on accept.
- Requests seen in any other state, including DONE, are ignored. Held requests are re-sampled once the FSM is back in IDLE.

FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, INV_ADDR, INV_DATA, DONE.

Read path:
- IDLE + read: go to RD_ADDR.
  - arvalid=1, araddr=latched address, arlen=LINE_WORDS-1, arsnoop=4'b0001.
  - Hold all AR fields stable until arready.
- On arready: go to RD_DATA. rready=1.
  - Each rvalid beat k writes fill_data[k*DATA_WIDTH +: DATA_WIDTH]. The beat counter increments.
  - A beat with rlast goes to DONE.
  - rack pulses for 1 cycle in the cycle after the last R handshake.

Write path:
- IDLE + write: go to WR_ADDR.
  - awvalid=1, awlen=LINE_WORDS-1, awsnoop=3'b011.
- On awready: go to WR_DATA.
  - wvalid=1, wdata=word k of the latched line.
  - wlast=1 on k=LINE_WORDS-1.
  - Advance on wready. After the last beat, go to WR_RESP.
- In WR_RESP, bready=1. On bvalid, go to DONE. wack pulses the next cycle.

Invalidate path:
- IDLE + invalid: go to INV_ADDR.
  - arvalid=1, arlen=0, arsnoop=4'b1011 (CleanUnique).
- On arready: go to INV_DATA. rready=1.
  - One R beat; data is discarded.
  - Then go to DONE. rack pulses.

Completion:
- DONE lasts exactly 1 cycle. ace_ready=1, and ace_error as set below. Then return to IDLE.
- Minimum request-to-ace_ready latency with zero-wait slave:
  - Read: 3+LINE_WORDS cycles.
  - Write: 4+LINE_WORDS cycles.
  - Invalidate: 4 cycles.

Errors:
- ace_error is set by any of:
  - rresp[1]=1 or bresp[1]=1 (SLVERR/DECERR).
  - rlast on a beat other than LINE_WORDS-1.
  - A beat at counter LINE_WORDS-1 without rlast.
- On a missing rlast, keep accepting beats, discarding beyond the line, until rlast.
- Completion still occurs on error.

Data and counters:
- fill_data is stable from DONE until the next read's first beat.
- The beat counter is log2(LINE_WORDS) bits and is cleared on each accept.

Handshake rules:
- valid is never deasserted before ready.
- rready, bready, and wvalid are only asserted in their own states.

Decomposition:
- Shared package ace_pkg:
  - FSM state enum.
  - ARSNOOP codes READ_SHARED=4'b0001 and CLEAN_UNIQUE=4'b1011.
  - AWSNOOP WRITE_BACK=3'b011.
  - RESP codes OKAY/EXOKAY/SLVERR/DECERR.
- No sub-module; beat counter and line buffer stay inline.

Test Plan:
- Read, zero-wait slave, LINE_WORDS=4, addr 0x1000, rdata 0xA0..0xA3:
  - AR shows 0x1000/arlen 3/arsnoop 0001.
  - ace_ready at cycle 7 with fill_data=0xA3A2A1A0 word-ordered.
  - rack pulses once.
- Writeback wb_data words 0x11,0x22,0x33,0x44, awready delayed 3 cycles, wready toggling:
  - awvalid held stable.
  - wdata 0x11..0x44 in order, wlast on 4th.
  - ace_ready after bvalid, then wack.
- invalid_req single-cycle pulse:
  - CleanUnique AR, arlen 0, one R beat.
  - ace_ready exactly once, fill_data unchanged.
- write_req and read_req asserted together, read_req still held at ace_ready:
  - WriteBack first.
  - ReadShared issued starting the cycle after return to IDLE.
- rresp=2'b10 on beat 2 and rlast on beat 2 (early):
  - ace_ready and ace_error pulse together. FSM back in IDLE.
- reset deasserted low during WR_DATA:
  - All outputs 0 immediately. IDLE after release. No wack, no ace_ready.
